// File: rtl/ei_axi4_tb_ctrl.sv
// Bench controller for the AXI4 VIP top: sequences DUT reset, times the run and watches every channel for hangs.
// Optional: define EI_AXI4_TB_CTRL_AUTO_RESTART_EN to let start in END launch another test without aresetn.
module ei_axi4_tb_ctrl #(
    parameter int NUM_CH         = 5,
    parameter int RST_CYCLES     = 16,
    parameter int HANG_LIMIT     = 256,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic              stop,
    input  logic [NUM_CH-1:0] valid,
    input  logic [NUM_CH-1:0] ready,
    output logic              dut_aresetn,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic [NUM_CH-1:0] hang,
    output logic              timeout,
    output logic              done
);
    // Handshake: channel i transfers in a cycle with valid[i] && ready[i]; valid[i] && !ready[i] is a stall cycle.
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int SW = $clog2(HANG_LIMIT + 1);
    localparam int PW = $clog2(NUM_CH + 1);
    localparam logic [RW-1:0]    RST_LAST  = RW'(RST_CYCLES - 1);
    localparam logic [SW-1:0]    STALL_MAX = SW'(HANG_LIMIT);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_END   = 2'd3
    } state_t;

    state_t            cur;
    logic [RW-1:0]     rst_cnt;
    logic [SW-1:0]     stall [NUM_CH];
    logic [PW-1:0]     pop;
    logic [NUM_CH-1:0] hang_hit;
    logic [CNT_W:0]    xfer_sum;
    logic [CNT_W-1:0]  cycle_next;
    logic [CNT_W-1:0]  xfer_next;

    assign state = cur;

    always_comb begin
        pop      = '0;
        hang_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop         = pop + PW'(valid[i] & ready[i]);
            hang_hit[i] = (stall[i] == STALL_MAX);
        end
        xfer_sum   = {1'b0, xfer_cnt} + (CNT_W + 1)'(pop);
        xfer_next  = xfer_sum[CNT_W] ? {CNT_W{1'b1}} : xfer_sum[CNT_W-1:0];
        cycle_next = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_W'(1);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cur         <= S_IDLE;
            dut_aresetn <= 1'b0;
            rst_cnt     <= '0;
            cycle_cnt   <= '0;
            xfer_cnt    <= '0;
            hang        <= '0;
            timeout     <= 1'b0;
            done        <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) stall[i] <= '0;
        end else begin
            case (cur)
                S_IDLE: begin
                    dut_aresetn <= 1'b0;
                    if (start) begin
                        cur     <= S_RESET;
                        rst_cnt <= '0;
                    end
                end
                S_RESET: begin
                    if (rst_cnt == RST_LAST) begin
                        cur         <= S_RUN;
                        dut_aresetn <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end
                S_RUN: begin
                    cycle_cnt <= cycle_next;
                    xfer_cnt  <= xfer_next;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (valid[i] && !ready[i]) begin
                            if (stall[i] != STALL_MAX) stall[i] <= stall[i] + SW'(1);
                        end else begin
                            stall[i] <= '0;
                        end
                    end
                    // Timeout exit leaves hang untouched so the end cause stays unambiguous.
                    if (stop) begin
                        cur  <= S_END;
                        done <= 1'b1;
                        hang <= hang | hang_hit;
                    end else if (cycle_cnt == TO_LAST) begin
                        cur     <= S_END;
                        timeout <= 1'b1;
                    end else begin
                        hang <= hang | hang_hit;
                        if (|hang) cur <= S_END;
                    end
                end
                S_END: begin
`ifdef EI_AXI4_TB_CTRL_AUTO_RESTART_EN
                    if (start) begin
                        cur         <= S_RESET;
                        dut_aresetn <= 1'b0;
                        rst_cnt     <= '0;
                        cycle_cnt   <= '0;
                        xfer_cnt    <= '0;
                        hang        <= '0;
                        timeout     <= 1'b0;
                        done        <= 1'b0;
                        for (int i = 0; i < NUM_CH; i++) stall[i] <= '0;
                    end
`else
                    cur <= S_END;
`endif
                end
                default: cur <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ei_axi4_tb_ctrl.sv
// Self-checking bench for ei_axi4_tb_ctrl: directed scenarios plus randomized runs scored against a run-level model.
// Honours EI_AXI4_TB_CTRL_AUTO_RESTART_EN when checking start in END.
module tb_ei_axi4_tb_ctrl;
    localparam int NUM_CH         = 5;
    localparam int RST_CYCLES     = 4;
    localparam int HANG_LIMIT     = 8;
    localparam int TIMEOUT_CYCLES = 60;
    localparam int CNT_W          = 32;
    localparam int MAXR           = 128;

    logic              aclk = 1'b0;
    logic              aresetn, start, stop;
    logic [NUM_CH-1:0] valid, ready;
    logic              dut_aresetn;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cycle_cnt, xfer_cnt;
    logic [NUM_CH-1:0] hang;
    logic              timeout, done;

    int checks   = 0;
    int failures = 0;
    int run_cycles;

    logic [NUM_CH-1:0] sv_valid [MAXR];
    logic [NUM_CH-1:0] sv_ready [MAXR];
    logic              sv_stop  [MAXR];
    logic [CNT_W-1:0]  exp_q[$];

    ei_axi4_tb_ctrl #(
        .NUM_CH(NUM_CH), .RST_CYCLES(RST_CYCLES), .HANG_LIMIT(HANG_LIMIT),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop),
        .valid(valid), .ready(ready), .dut_aresetn(dut_aresetn), .state(state),
        .cycle_cnt(cycle_cnt), .xfer_cnt(xfer_cnt), .hang(hang),
        .timeout(timeout), .done(done)
    );

    // Clock and reset
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        aresetn = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        valid   = '0;
        ready   = '0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    // Driver tasks
    task automatic clear_stim();
        for (int r = 0; r < MAXR; r++) begin
            sv_valid[r] = '0;
            sv_ready[r] = '0;
            sv_stop[r]  = 1'b0;
        end
    endtask

    task automatic bring_up();
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        for (int i = 0; i < RST_CYCLES + 4 && state != 2'd2; i++) @(negedge aclk);
        checks++;
        if (state !== 2'd2) begin failures++; $display("FAIL bring_up_state got=%0d exp=2", state); end
    endtask

    task automatic drive_run();
        run_cycles = 0;
        while (run_cycles < MAXR && state == 2'd2) begin
            valid = sv_valid[run_cycles];
            ready = sv_ready[run_cycles];
            stop  = sv_stop[run_cycles];
            @(negedge aclk);
            run_cycles++;
        end
        valid = '0;
        ready = '0;
        stop  = 1'b0;
    endtask

    // Run-level model: find the first stall streak reaching HANG_LIMIT per channel, then the exit cycle.
    task automatic predict(output int e_cyc, output logic [CNT_W-1:0] e_xfer,
                           output logic [NUM_CH-1:0] e_hang, output logic e_done, output logic e_to);
        int   hang_at [NUM_CH];
        int   streak;
        int   last;
        logic any_hang;
        e_xfer = '0;
        e_hang = '0;
        e_done = 1'b0;
        e_to   = 1'b0;
        last   = MAXR - 1;
        for (int c = 0; c < NUM_CH; c++) begin
            hang_at[c] = -1;
            streak     = 0;
            for (int r = 0; r < MAXR; r++) begin
                streak = (sv_valid[r][c] && !sv_ready[r][c]) ? streak + 1 : 0;
                if (streak == HANG_LIMIT && hang_at[c] < 0) hang_at[c] = r + 1;
            end
        end
        for (int r = 0; r < MAXR; r++) begin
            any_hang = 1'b0;
            for (int c = 0; c < NUM_CH; c++)
                if (hang_at[c] >= 0 && hang_at[c] < r) any_hang = 1'b1;
            if (sv_stop[r]) begin e_done = 1'b1; last = r; break; end
            if (r == TIMEOUT_CYCLES - 1) begin e_to = 1'b1; last = r; break; end
            if (any_hang) begin last = r; break; end
        end
        for (int r = 0; r <= last; r++)
            e_xfer = e_xfer + CNT_W'($countones(sv_valid[r] & sv_ready[r]));
        for (int c = 0; c < NUM_CH; c++)
            e_hang[c] = (hang_at[c] >= 0) && (hang_at[c] < last || (hang_at[c] == last && !e_to));
        e_cyc = last + 1;
    endtask

    // Scenarios
    task automatic test_reset();
        aresetn = 1'b0; start = 1'b1; stop = 1'b1; valid = '1; ready = '0;
        repeat (3) @(negedge aclk);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (dut_aresetn !== 1'b0) begin failures++; $display("FAIL reset_dut_aresetn got=%0b exp=0", dut_aresetn); end
        checks++; if (cycle_cnt !== '0) begin failures++; $display("FAIL reset_cycle_cnt got=%0d exp=0", cycle_cnt); end
        checks++; if (xfer_cnt !== '0) begin failures++; $display("FAIL reset_xfer_cnt got=%0d exp=0", xfer_cnt); end
        checks++; if (hang !== '0) begin failures++; $display("FAIL reset_hang got=%b exp=00000", hang); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%0b exp=0", timeout); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        aresetn = 1'b1; start = 1'b0; valid = '0;
        repeat (3) @(negedge aclk);
        checks++; if (state !== 2'd0 || dut_aresetn !== 1'b0) begin failures++; $display("FAIL idle_stop_ignored state=%0d dut_aresetn=%0b exp state=0 dut_aresetn=0", state, dut_aresetn); end
        stop = 1'b0;
    endtask

    task automatic test_reset_seq();
        apply_reset();
        start = 1'b1;
        for (int k = 0; k < RST_CYCLES; k++) begin
            @(negedge aclk);
            checks++;
            if (state !== 2'd1 || dut_aresetn !== 1'b0) begin failures++; $display("FAIL rst_seq_cycle%0d state=%0d dut_aresetn=%0b exp state=1 dut_aresetn=0", k, state, dut_aresetn); end
        end
        @(negedge aclk);
        checks++; if (state !== 2'd2 || dut_aresetn !== 1'b1) begin failures++; $display("FAIL rst_seq_release state=%0d dut_aresetn=%0b exp state=2 dut_aresetn=1", state, dut_aresetn); end
        checks++; if (cycle_cnt !== '0) begin failures++; $display("FAIL rst_seq_cycle_cnt got=%0d exp=0", cycle_cnt); end
        repeat (3) @(negedge aclk);
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL start_held_in_run got=%0d exp=2", state); end
        start = 1'b0; stop = 1'b1;
        @(negedge aclk);
        stop = 1'b0;
        checks++; if (state !== 2'd3 || done !== 1'b1) begin failures++; $display("FAIL rst_seq_stop state=%0d done=%0b exp state=3 done=1", state, done); end
        checks++; if (cycle_cnt !== 32'd4) begin failures++; $display("FAIL rst_seq_stop_cycles got=%0d exp=4", cycle_cnt); end
    endtask

    task automatic test_clean_stop();
        clear_stim();
        for (int r = 0; r < 50; r++) begin sv_valid[r] = 5'b00011; sv_ready[r] = 5'b00011; end
        sv_stop[49] = 1'b1;
        apply_reset(); bring_up(); drive_run();
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL stop_state got=%0d exp=3", state); end
        checks++; if (done !== 1'b1 || timeout !== 1'b0) begin failures++; $display("FAIL stop_flags done=%0b timeout=%0b exp done=1 timeout=0", done, timeout); end
        checks++; if (cycle_cnt !== 32'd50) begin failures++; $display("FAIL stop_cycle_cnt got=%0d exp=50", cycle_cnt); end
        checks++; if (xfer_cnt !== 32'd100) begin failures++; $display("FAIL stop_xfer_cnt got=%0d exp=100", xfer_cnt); end
        checks++; if (hang !== '0 || dut_aresetn !== 1'b1) begin failures++; $display("FAIL stop_hang_rst hang=%b dut_aresetn=%0b exp hang=00000 dut_aresetn=1", hang, dut_aresetn); end
    endtask

    task automatic test_timeout();
        int               e_cyc;
        logic [CNT_W-1:0] e_xfer;
        logic [NUM_CH-1:0] e_hang;
        logic             e_done, e_to;
        clear_stim();
        for (int r = 0; r < MAXR; r++) begin
            sv_valid[r] = NUM_CH'($urandom);
            sv_ready[r] = sv_valid[r] | NUM_CH'($urandom);
        end
        predict(e_cyc, e_xfer, e_hang, e_done, e_to);
        apply_reset(); bring_up(); drive_run();
        checks++; if (state !== 2'd3 || timeout !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL timeout_flags state=%0d timeout=%0b done=%0b exp state=3 timeout=1 done=0", state, timeout, done); end
        checks++; if (cycle_cnt !== CNT_W'(TIMEOUT_CYCLES)) begin failures++; $display("FAIL timeout_cycle_cnt got=%0d exp=%0d", cycle_cnt, TIMEOUT_CYCLES); end
        checks++; if (xfer_cnt !== e_xfer) begin failures++; $display("FAIL timeout_xfer_cnt got=%0d exp=%0d", xfer_cnt, e_xfer); end
        checks++; if (hang !== '0) begin failures++; $display("FAIL timeout_hang got=%b exp=00000", hang); end
    endtask

    task automatic test_hang();
        clear_stim();
        for (int r = 0; r < MAXR; r++) sv_valid[r] = 5'b10000;
        apply_reset(); bring_up(); drive_run();
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL hang_state got=%0d exp=3", state); end
        checks++; if (hang !== 5'b10000) begin failures++; $display("FAIL hang_bits got=%b exp=10000", hang); end
        checks++; if (done !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL hang_flags done=%0b timeout=%0b exp 0 0", done, timeout); end
        checks++; if (cycle_cnt !== CNT_W'(HANG_LIMIT + 2)) begin failures++; $display("FAIL hang_cycle_cnt got=%0d exp=%0d", cycle_cnt, HANG_LIMIT + 2); end
    endtask

    task automatic test_ready_pulse();
        clear_stim();
        for (int r = 0; r < 15; r++) sv_valid[r] = 5'b10000;
        sv_ready[7] = 5'b10000;
        sv_stop[15] = 1'b1;
        apply_reset(); bring_up(); drive_run();
        checks++; if (hang !== '0) begin failures++; $display("FAIL pulse_hang got=%b exp=00000", hang); end
        checks++; if (state !== 2'd3 || done !== 1'b1) begin failures++; $display("FAIL pulse_end state=%0d done=%0b exp state=3 done=1", state, done); end
        checks++; if (cycle_cnt !== 32'd16 || xfer_cnt !== 32'd1) begin failures++; $display("FAIL pulse_counts cycle=%0d xfer=%0d exp cycle=16 xfer=1", cycle_cnt, xfer_cnt); end
    endtask

    task automatic test_stop_vs_timeout();
        clear_stim();
        sv_stop[TIMEOUT_CYCLES-1] = 1'b1;
        apply_reset(); bring_up(); drive_run();
        checks++; if (done !== 1'b1 || timeout !== 1'b0) begin failures++; $display("FAIL stop_beats_timeout done=%0b timeout=%0b exp done=1 timeout=0", done, timeout); end
        checks++; if (cycle_cnt !== CNT_W'(TIMEOUT_CYCLES)) begin failures++; $display("FAIL stop_beats_timeout_cycles got=%0d exp=%0d", cycle_cnt, TIMEOUT_CYCLES); end
    endtask

    task automatic test_hang_with_stop();
        clear_stim();
        for (int r = 0; r < MAXR; r++) sv_valid[r] = 5'b00100;
        sv_stop[HANG_LIMIT] = 1'b1;
        apply_reset(); bring_up(); drive_run();
        checks++; if (hang !== 5'b00100) begin failures++; $display("FAIL hang_stop_bits got=%b exp=00100", hang); end
        checks++; if (done !== 1'b1 || timeout !== 1'b0) begin failures++; $display("FAIL hang_stop_flags done=%0b timeout=%0b exp done=1 timeout=0", done, timeout); end
        checks++; if (cycle_cnt !== CNT_W'(HANG_LIMIT + 1)) begin failures++; $display("FAIL hang_stop_cycles got=%0d exp=%0d", cycle_cnt, HANG_LIMIT + 1); end
    endtask

    task automatic test_mid_run_reset();
        apply_reset(); bring_up();
        valid = '1; ready = '1;
        repeat (10) @(negedge aclk);
        checks++; if (cycle_cnt !== 32'd10 || xfer_cnt !== 32'd50) begin failures++; $display("FAIL mid_run_counts cycle=%0d xfer=%0d exp cycle=10 xfer=50", cycle_cnt, xfer_cnt); end
        aresetn = 1'b0;
        @(negedge aclk);
        checks++; if (state !== 2'd0 || dut_aresetn !== 1'b0) begin failures++; $display("FAIL mid_run_reset_state state=%0d dut_aresetn=%0b exp 0 0", state, dut_aresetn); end
        checks++; if (cycle_cnt !== '0 || xfer_cnt !== '0) begin failures++; $display("FAIL mid_run_reset_counts cycle=%0d xfer=%0d exp 0 0", cycle_cnt, xfer_cnt); end
        checks++; if (hang !== '0 || done !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL mid_run_reset_flags hang=%b done=%0b timeout=%0b exp all 0", hang, done, timeout); end
        aresetn = 1'b1; valid = '0; ready = '0;
    endtask

    task automatic test_start_in_end();
        clear_stim();
        for (int r = 0; r < 5; r++) begin sv_valid[r] = 5'b00001; sv_ready[r] = 5'b00001; end
        sv_stop[4] = 1'b1;
        apply_reset(); bring_up(); drive_run();
        start = 1'b1; stop = 1'b1;
        @(negedge aclk);
        start = 1'b0; stop = 1'b0;
`ifdef EI_AXI4_TB_CTRL_AUTO_RESTART_EN
        checks++; if (state !== 2'd1 || dut_aresetn !== 1'b0) begin failures++; $display("FAIL restart_state state=%0d dut_aresetn=%0b exp state=1 dut_aresetn=0", state, dut_aresetn); end
        checks++; if (cycle_cnt !== '0 || xfer_cnt !== '0) begin failures++; $display("FAIL restart_counts cycle=%0d xfer=%0d exp 0 0", cycle_cnt, xfer_cnt); end
        checks++; if (done !== 1'b0 || timeout !== 1'b0 || hang !== '0) begin failures++; $display("FAIL restart_flags done=%0b timeout=%0b hang=%b exp all 0", done, timeout, hang); end
        for (int i = 0; i < RST_CYCLES + 4 && state != 2'd2; i++) @(negedge aclk);
        stop = 1'b1;
        @(negedge aclk);
        stop = 1'b0;
        checks++; if (state !== 2'd3 || done !== 1'b1 || cycle_cnt !== 32'd1) begin failures++; $display("FAIL restart_second_run state=%0d done=%0b cycle=%0d exp 3 1 1", state, done, cycle_cnt); end
`else
        repeat (3) @(negedge aclk);
        checks++; if (state !== 2'd3 || dut_aresetn !== 1'b1) begin failures++; $display("FAIL end_terminal state=%0d dut_aresetn=%0b exp state=3 dut_aresetn=1", state, dut_aresetn); end
        checks++; if (done !== 1'b1 || cycle_cnt !== 32'd5 || xfer_cnt !== 32'd5) begin failures++; $display("FAIL end_frozen done=%0b cycle=%0d xfer=%0d exp 1 5 5", done, cycle_cnt, xfer_cnt); end
`endif
    endtask

    task automatic test_random();
        int                e_cyc;
        logic [CNT_W-1:0]  e_xfer;
        logic [NUM_CH-1:0] e_hang;
        logic              e_done, e_to;
        logic [NUM_CH-1:0] rdy_bias;
        logic [CNT_W-1:0]  exp_v;
        int                stuck_ch, stuck_from, stop_at;
        for (int it = 0; it < 24; it++) begin
            clear_stim();
            rdy_bias   = NUM_CH'($urandom);
            stuck_ch   = -1;
            if ($urandom_range(0, 1) == 1) stuck_ch = int'($urandom_range(0, NUM_CH - 1));
            stuck_from = int'($urandom_range(0, 50));
            stop_at    = int'($urandom_range(0, 90));
            for (int r = 0; r < MAXR; r++) begin
                sv_valid[r] = NUM_CH'($urandom);
                sv_ready[r] = NUM_CH'($urandom) | rdy_bias;
                if (stuck_ch >= 0 && r >= stuck_from) begin
                    sv_valid[r][stuck_ch] = 1'b1;
                    sv_ready[r][stuck_ch] = 1'b0;
                end
                sv_stop[r] = (r == stop_at);
            end
            predict(e_cyc, e_xfer, e_hang, e_done, e_to);
            exp_q.push_back(CNT_W'(e_cyc));
            exp_q.push_back(e_xfer);
            apply_reset(); bring_up(); drive_run();
            checks++; if (state !== 2'd3) begin failures++; $display("FAIL rand%0d_state got=%0d exp=3", it, state); end
            exp_v = exp_q.pop_front();
            checks++; if (cycle_cnt !== exp_v) begin failures++; $display("FAIL rand%0d_cycle_cnt got=%0d exp=%0d", it, cycle_cnt, exp_v); end
            exp_v = exp_q.pop_front();
            checks++; if (xfer_cnt !== exp_v) begin failures++; $display("FAIL rand%0d_xfer_cnt got=%0d exp=%0d", it, xfer_cnt, exp_v); end
            checks++; if (hang !== e_hang) begin failures++; $display("FAIL rand%0d_hang got=%b exp=%b", it, hang, e_hang); end
            checks++; if (done !== e_done || timeout !== e_to) begin failures++; $display("FAIL rand%0d_flags done=%0b timeout=%0b exp done=%0b timeout=%0b", it, done, timeout, e_done, e_to); end
        end
    endtask

    initial begin
        test_reset();
        test_reset_seq();
        test_clean_stop();
        test_timeout();
        test_hang();
        test_ready_pulse();
        test_stop_vs_timeout();
        test_hang_with_stop();
        test_mid_run_reset();
        test_start_in_end();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ei_axi4_tb_ctrl.md
Name: ei_axi4_tb_ctrl

Overview:
Synthesisable bench controller for the AXI4 VIP top level, replacing the bench's free-running reset and fixed-delay finish with counted, observable control.
- Sequences DUT reset release.
- Counts run cycles against a programmable timeout.
- Watches every AXI channel's VALID/READY pair for hangs.
- Reports done/timeout/hang status that the test reads to end simulation.

Parameters:
NUM_CH, 5, number of monitored channels; bit order AW=0, W=1, B=2, AR=3, R=4.
RST_CYCLES, 16, cycles dut_aresetn is held low after start (>=1).
HANG_LIMIT, 256, consecutive VALID&&!READY cycles on one channel that flag a hang (>=1).
TIMEOUT_CYCLES, 1000, RUN cycles before timeout (>=1).
CNT_W, 32, width of cycle and transfer counters.

Ports:
aclk  in  1  single clock; all logic on rising edge.
aresetn  in  1  synchronous, active-low reset.
start  in  1  one-cycle pulse; begins reset sequence from IDLE.
stop  in  1  test-complete request; honoured in RUN only.
valid  in  NUM_CH  per-channel VALID.
ready  in  NUM_CH  per-channel READY.
dut_aresetn  out  1  registered reset to DUT/interface.
state  out  2  IDLE=0, RESET=1, RUN=2, END=3.
cycle_cnt  out  CNT_W  RUN cycles elapsed, saturating.
xfer_cnt  out  CNT_W  total handshakes (valid&ready bits) in RUN, saturating.
hang  out  NUM_CH  sticky per-channel hang flags.
timeout  out  1  sticky; timeout ended the run.
done  out  1  sticky; stop ended the run.

Behaviour:
- Reset (aresetn=0 at edge): state=IDLE; dut_aresetn=0; cycle_cnt=0; xfer_cnt=0; hang=0; timeout=0; done=0; all internal counters=0. Reset has priority in every state, including mid-RUN.
- IDLE:
  - dut_aresetn=0.
  - start=1 -> RESET with reset counter cleared.
  - stop is ignored.
- RESET:
  - dut_aresetn=0 for exactly RST_CYCLES cycles counted from the first RESET cycle.
  - Last RESET cycle -> RUN; dut_aresetn=1 from the first RUN cycle (registered).
  - start, stop, valid and ready are ignored.
- RUN, each cycle:
  - cycle_cnt+=1, saturating at all-ones.
  - xfer_cnt+=popcount(valid&ready), saturating.
  - Per channel i: stall counter increments when valid[i]&&!ready[i]; clears otherwise.
  - When a stall counter reaches HANG_LIMIT, hang[i]=1 on the following edge; the stall counter saturates.
- RUN exit checks, evaluated on registered values, same edge:
  - stop=1 -> END, done=1.
  - Else cycle_cnt==TIMEOUT_CYCLES-1 in this cycle -> END, timeout=1. The counter increments on that edge, so cycle_cnt=TIMEOUT_CYCLES in END.
  - Else any hang bit set -> END, done=0, timeout=0.
  - stop beats timeout when simultaneous: done=1, timeout=0.
  - A hang bit set on the same edge as stop is still recorded.
- END:
  - All counters and flags frozen; dut_aresetn stays 1.
  - start and stop are ignored; exit only via aresetn (see Optional Feature).
  - Exactly one of done, timeout or |hang is the cause; hang may coexist with done.
- Boundary cases:
  - start held high: acted on once in IDLE only.
  - HANG_LIMIT=1: hang set one edge after the first stalled cycle.
  - No combinational path from inputs to outputs.

Optional Feature:
EI_AXI4_TB_CTRL_AUTO_RESTART_EN
- Defined: start=1 in END -> RESET on the next edge; cycle_cnt, xfer_cnt, hang, timeout, done and stall counters cleared on that edge; dut_aresetn driven 0. Supports back-to-back tests without global reset.
- Undefined: END is terminal until aresetn; start in END has no effect.

Test Plan:
- Reset sequence: RST_CYCLES=4, start pulse at cycle 10 -> dut_aresetn=0 through cycle 14, 1 at cycle 15; state RESET(1) at 11-14, RUN(2) at 15.
- Clean stop: RUN 50 cycles with valid=ready=5'b00011 every cycle, then stop -> state=3, done=1, timeout=0, cycle_cnt=50, xfer_cnt=100.
- Timeout: TIMEOUT_CYCLES=20, no stop -> END after 20 RUN cycles, timeout=1, cycle_cnt=20, done=0.
- Hang: HANG_LIMIT=8, valid[4]=1 and ready[4]=0 held -> hang=5'b10000 one edge after the 8th stalled cycle, then END. Also: a ready pulse at stall 7 restarts the count, and no hang occurs.
- Simultaneous stop and timeout at cycle TIMEOUT_CYCLES-1 -> done=1, timeout=0. Mid-RUN aresetn=0 -> every output back to its reset value on the next edge.
- With EI_AXI4_TB_CTRL_AUTO_RESTART_EN: start in END -> state=RESET, all flags and counters 0, dut_aresetn=0 next edge. Without the macro -> state remains END.
